// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the MEM pipeline stage.
//   WORD_W          : datapath word width (32).
//   IDLE/ACCESS/DONE: FSM state encoding of the data-memory sequencer.
//   mem_wb_t        : contents of the MEM/WB pipeline register.
package mem_stage_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  typedef struct packed {
    logic [WORD_W-1:0] read_data;
    logic [WORD_W-1:0] alu_result;
    logic [4:0]        wreg_addr;
    logic              reg_write;
    logic              mem_to_reg;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory request/acknowledge bus.
//   DMem_req/we/addr/wdata : request side, driven by the MEM stage (master).
//   DMem_ack/rdata         : response side, driven by the memory (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              DMem_req;
  logic              DMem_we;
  logic [WORD_W-1:0] DMem_addr;
  logic [WORD_W-1:0] DMem_wdata;
  logic              DMem_ack;
  logic [WORD_W-1:0] DMem_rdata;

  modport master (
    output DMem_req, DMem_we, DMem_addr, DMem_wdata,
    input  DMem_ack, DMem_rdata
  );

  modport slave (
    input  DMem_req, DMem_we, DMem_addr, DMem_wdata,
    output DMem_ack, DMem_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg -- MEM/WB pipeline register.
//   CLK, RST : clock, synchronous active-high reset (clears all fields).
//   load     : capture d.
//   bubble   : insert a bubble (clear write-back controls); wins over load.
//   d, q     : register input / output.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    CLK,
  input  logic    RST,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // NOTE: sequential state is always written with <= so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (bubble) begin
      // Data fields are don't-care in a bubble; only the controls matter.
      q.reg_write  <= 1'b0;
      q.mem_to_reg <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage: data-memory sequencer, PC redirect and
// MEM/WB register.
//   CLK, RST            : clock, synchronous active-high reset.
//   *4 / *_addr1 inputs : instruction fields from the EX/MEM register.
//   dmem                : data-memory bus (req/we/addr/wdata out, ack/rdata in).
//   Stall               : freeze upstream registers while a memory op runs.
//   PC_redirect/target  : jump or taken-branch redirect (jump has priority).
//   Misalign            : sticky flag, set by a non-word-aligned memory op.
//   *5 outputs          : MEM/WB register contents.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] ALUResult4,
  input  logic [WORD_W-1:0] WriteData4,
  input  logic [4:0]        Wreg_addr4,
  input  logic [WORD_W-1:0] Branch_addr1,
  input  logic [WORD_W-1:0] Jump_addr1,
  input  logic              PCSrc4,
  input  logic              JtoPC4,
  input  logic              Branch4,
  input  logic              RegWrite4,
  input  logic              MemWrite4,
  input  logic              MemRead4,
  input  logic              MemtoReg4,
  mem_stage_if.master       dmem,
  output logic              Stall,
  output logic              PC_redirect,
  output logic [WORD_W-1:0] PC_target,
  output logic              Misalign,
  output logic [WORD_W-1:0] ReadData5,
  output logic [WORD_W-1:0] ALUResult5,
  output logic [4:0]        Wreg_addr5,
  output logic              RegWrite5,
  output logic              MemtoReg5
);

  logic [1:0]        state;
  logic [WORD_W-1:0] rdata_q;
  logic              mem_op;
  logic              aligned;
  logic              wb_load;
  logic              wb_bubble;
  mem_wb_t           wb_d;
  mem_wb_t           wb_q;

  assign mem_op  = MemRead4 | MemWrite4;
  assign aligned = (ALUResult4[1:0] == 2'b00);

  // Sequencer. The EX/MEM register is frozen by Stall until DONE, so the
  // instruction inputs remain valid through the DONE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      dmem.DMem_req    <= 1'b0;
      dmem.DMem_we     <= 1'b0;
      dmem.DMem_addr   <= '0;
      dmem.DMem_wdata  <= '0;
      Misalign         <= 1'b0;
      rdata_q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (aligned) begin
              state           <= ACCESS;
              dmem.DMem_req   <= 1'b1;
              dmem.DMem_we    <= MemWrite4;
              dmem.DMem_addr  <= ALUResult4;
              dmem.DMem_wdata <= WriteData4;
            end else begin
              Misalign <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (dmem.DMem_ack) begin
            rdata_q       <= dmem.DMem_rdata;
            dmem.DMem_req <= 1'b0;
            state         <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    Stall     = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    case (state)
      IDLE: begin
        Stall     = mem_op & aligned;
        // A misaligned op retires as a bubble without stalling.
        wb_bubble = mem_op;
        wb_load   = ~mem_op;
      end
      ACCESS: begin
        Stall     = 1'b1;
        wb_bubble = 1'b1;
      end
      DONE:    wb_load = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wb_d            = '0;
    wb_d.alu_result = ALUResult4;
    wb_d.wreg_addr  = Wreg_addr4;
    wb_d.reg_write  = RegWrite4;
    wb_d.mem_to_reg = MemtoReg4;
    // Read+write together behaves as a store, so no read data is returned.
    if (state == DONE && MemRead4 && !MemWrite4) begin
      wb_d.read_data = rdata_q;
    end
  end

  assign PC_redirect = (JtoPC4 | (Branch4 & PCSrc4)) & (state == IDLE);
  assign PC_target   = JtoPC4 ? Jump_addr1 : Branch_addr1;

  mem_wb_reg u_mem_wb_reg (
    .CLK    (CLK),
    .RST    (RST),
    .load   (wb_load),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign ReadData5  = wb_q.read_data;
  assign ALUResult5 = wb_q.alu_result;
  assign Wreg_addr5 = wb_q.wreg_addr;
  assign RegWrite5  = wb_q.reg_write;
  assign MemtoReg5  = wb_q.mem_to_reg;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-002 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-003 SHALL have inputs ALUResult4[31:0], WriteData4[31:0], Wreg_addr4[4:0], Branch_addr1[31:0], Jump_addr1[31:0] from the EX/MEM register.
REQ-004 SHALL have 1-bit inputs PCSrc4, JtoPC4, Branch4, RegWrite4, MemWrite4, MemRead4, MemtoReg4 from the EX/MEM register.
REQ-005 SHALL have data-memory ports: DMem_req out 1, DMem_we out 1, DMem_addr out 32, DMem_wdata out 32, DMem_ack in 1, DMem_rdata in 32.
REQ-006 SHALL have outputs Stall 1 (freeze upstream registers), PC_redirect 1, PC_target 32, Misalign 1 (sticky error).
REQ-007 SHALL have MEM/WB outputs ReadData5[31:0], ALUResult5[31:0], Wreg_addr5[4:0], RegWrite5, MemtoReg5.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, DONE; MemOp = MemRead4 | MemWrite4.
REQ-009 IDLE with MemOp and ALUResult4[1:0]==0 SHALL go to ACCESS, registering DMem_addr=ALUResult4, DMem_wdata=WriteData4, DMem_we=MemWrite4.
REQ-010 ACCESS SHALL hold DMem_req=1 with address/data/we stable until DMem_ack=1, then capture DMem_rdata and go to DONE.
REQ-011 DONE SHALL drop DMem_req and return to IDLE after exactly one cycle.
REQ-012 Stall SHALL be combinational: 1 in ACCESS; 1 in IDLE when a legal MemOp is present; 0 in DONE and otherwise.
REQ-013 MEM/WB register SHALL load the held instruction in DONE (ReadData5 = captured data for loads, 0 for stores) and any non-MemOp instruction in IDLE (1-cycle latency).
REQ-014 While Stall=1, MEM/WB SHALL load a bubble: RegWrite5=0, MemtoReg5=0; other fields don't-care.
REQ-015 Load latency SHALL be 3 cycles minimum (IDLE detect, ACCESS with ack, DONE) to ReadData5 valid, plus one per extra ack wait cycle.
REQ-016 MemRead4 and MemWrite4 both 1 SHALL perform a store only; ReadData5=0.
REQ-017 MemOp with ALUResult4[1:0]!=0 SHALL issue no request, set Misalign=1 until reset, assert no Stall, and retire as a bubble.
REQ-018 PC_redirect SHALL be combinational, = (JtoPC4 | (Branch4 & PCSrc4)) gated by state==IDLE.
REQ-019 PC_target SHALL be Jump_addr1 if JtoPC4, else Branch_addr1 (jump has priority).
REQ-020 DMem_ack outside ACCESS SHALL be ignored.

Reset
REQ-021 RST=1 at a rising edge SHALL force state IDLE, DMem_req=0, DMem_we=0, DMem_addr=0, DMem_wdata=0, Misalign=0, and all MEM/WB outputs to 0.
REQ-022 Reset during ACCESS SHALL abandon the access; DMem_req SHALL be 0 the next cycle, and a late ack SHALL be ignored.

Structure
REQ-023 Package mem_stage_pkg SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the 32-bit word-width constant.
REQ-024 The MEM/WB register SHALL be a sub-module mem_wb_reg with load and bubble inputs; FSM and redirect logic SHALL stay in mem_stage.

Verification
REQ-025 ALU op: RegWrite4=1, ALUResult4=0x00000010, Wreg_addr4=5 -> next edge ALUResult5=0x10, Wreg_addr5=5, RegWrite5=1, Stall never high.
REQ-026 Load: MemRead4=1, ALUResult4=0x100, ack 2 cycles after req with rdata=0xDEADBEEF -> Stall high 4 cycles, DMem_req high 3 cycles, ReadData5=0xDEADBEEF, exactly one RegWrite5=1 pulse.
REQ-027 Store: MemWrite4=1, ALUResult4=0x200, WriteData4=0x12345678, ack same cycle as req -> one request with DMem_we=1, DMem_addr=0x200, DMem_wdata=0x12345678, RegWrite5=0.
REQ-028 Misaligned: MemRead4=1, ALUResult4=0x102 -> no DMem_req, Misalign=1 and stays 1, RegWrite5=0.
REQ-029 Redirect: Branch4=1, PCSrc4=1, JtoPC4=1, Jump_addr1=0x400, Branch_addr1=0x80 -> PC_redirect=1, PC_target=0x400 the same cycle.
REQ-030 Reset mid-ACCESS: RST pulsed while DMem_req=1, ack arrives next cycle -> DMem_req=0, state IDLE, all outputs 0, no RegWrite5 pulse.
